// File: rtl/poly_result_collector_if.sv
// Term-in / coefficient-out stream bundle for the polynomial result collector.
// The master drives terms and out_ready; the slave is the collector.
interface poly_result_collector_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 4,
    parameter int unsigned IW = 3
) ();
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_idx;
    logic [CW-1:0] in_coeff;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_coeff;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          err;

    modport master (
        output in_valid, in_idx, in_coeff, in_last, out_ready,
        input  in_ready, out_valid, out_coeff, out_idx, out_last, err
    );

    modport slave (
        input  in_valid, in_idx, in_coeff, in_last, out_ready,
        output in_ready, out_valid, out_coeff, out_idx, out_last, err
    );
endinterface

// File: rtl/poly_result_collector.sv
// Accumulates partial-product terms into a negacyclic (mod x^N + 1) result polynomial,
// then drains it one coefficient per handshake and clears itself for the next product.
module poly_result_collector #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 4,
    parameter int unsigned IW = 3
) (
    input logic                   clk,
    input logic                   reset,
    poly_result_collector_if.slave bus
);
    localparam int unsigned PW = $clog2(N);

    typedef enum logic [0:0] {StAcc, StDrain} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] acc_q [N];
    logic [CW-1:0] acc_d [N];
    logic [PW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;

    logic [31:0]   idx_ext;
    logic [PW-1:0] slot;
    logic          at_last;
    logic          draining;

    // N is a power of two, so idx and idx-N share the same low bits.
    assign idx_ext  = 32'(bus.in_idx);
    assign slot     = bus.in_idx[PW-1:0];
    assign at_last  = (ptr_q == PW'(N - 1));
    assign draining = (state_q == StDrain);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        unique case (state_q)
            StAcc: begin
                if (bus.in_valid) begin
                    if (idx_ext < N) begin
                        acc_d[slot] = acc_q[slot] + bus.in_coeff;
                    end else if (idx_ext <= 2 * N - 2) begin
                        acc_d[slot] = acc_q[slot] - bus.in_coeff;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (bus.in_last) begin
                        state_d = StDrain;
                        ptr_d   = '0;
                    end
                end
            end
            StDrain: begin
                if (bus.out_ready) begin
                    ptr_d = ptr_q + 1'b1;
                    if (at_last) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            acc_d[i] = '0;
                        end
                        ptr_d   = '0;
                        state_d = StAcc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StAcc;
            acc_q   <= '{default: '0};
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == StAcc);
    assign bus.out_valid = draining;
    assign bus.out_coeff = draining ? acc_q[ptr_q] : '0;
    assign bus.out_idx   = draining ? IW'(ptr_q) : '0;
    assign bus.out_last  = draining && at_last;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_poly_result_collector.sv
// Directed and randomized bench for poly_result_collector, checked against an
// arithmetic model of the negacyclic accumulation.
module tb_poly_result_collector;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = 3;
    localparam int MASK = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    poly_result_collector_if #(.N(N), .CW(CW), .IW(IW)) bus ();

    poly_result_collector #(.N(N), .CW(CW), .IW(IW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    int model_acc [N];
    bit model_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) model_acc[i] = 0;
    endtask

    // x^N = -1: high-half terms subtract from the folded slot.
    task automatic model_apply(input int idx, input int c);
        if (idx < N) model_acc[idx] = (model_acc[idx] + c) & MASK;
        else if (idx <= 2 * N - 2) model_acc[idx - N] = (model_acc[idx - N] - c) & MASK;
        else model_err = 1'b1;
    endtask

    task automatic send(input int idx, input int c, input bit last);
        @(negedge clk);
        check("in_ready_acc", bus.in_ready, 1);
        check("out_valid_acc", bus.out_valid, 0);
        check("err_acc", bus.err, model_err);
        bus.in_valid = 1'b1;
        bus.in_idx   = IW'(idx);
        bus.in_coeff = CW'(c);
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        model_apply(idx, c);
    endtask

    task automatic drain(input int first_stall, input int max_stall, input bit noise);
        for (int p = 0; p < N; p++) begin
            int stall;
            logic [CW-1:0] held;
            stall = (p == 0) ? first_stall : int'($urandom_range(0, max_stall));
            held  = 'x;
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk);
                bus.out_ready = (s == stall);
                if (noise) begin
                    bus.in_valid = 1'($urandom);
                    bus.in_idx   = IW'($urandom);
                    bus.in_coeff = CW'($urandom);
                    bus.in_last  = 1'($urandom);
                end
                check("out_valid", bus.out_valid, 1);
                check("out_idx", bus.out_idx, p);
                check("out_coeff", bus.out_coeff, model_acc[p]);
                check("out_last", bus.out_last, (p == N - 1));
                check("in_ready_drain", bus.in_ready, 0);
                check("err_drain", bus.err, model_err);
                if (s > 0) check("out_coeff_stable", bus.out_coeff, held);
                held = bus.out_coeff;
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b0;
            bus.in_last   = 1'b0;
        end
        model_clear();
        @(negedge clk);
        check("in_ready_after", bus.in_ready, 1);
        check("out_valid_after", bus.out_valid, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_idx    = '0;
        bus.in_coeff  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();
        model_err = 1'b0;

        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_coeff", bus.out_coeff, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_err", bus.err, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);

        // Basic fold: (0,5),(1,3),(4,2) -> 3,3,0,0
        send(0, 5, 0);
        send(1, 3, 0);
        send(4, 2, 1);
        check("basic_c0", model_acc[0], 3);
        drain(0, 0, 0);

        // Modular wrap: 15 + 3 = 2
        send(2, 15, 0);
        send(2, 3, 1);
        check("wrap_c2", model_acc[2], 2);
        drain(0, 1, 0);

        // Lone high-half term folds to a negative coefficient
        send(5, 1, 1);
        check("neg_c1", model_acc[1], 15);
        drain(0, 0, 0);

        // Backpressure on coefficient 0 with ignored input traffic
        send(3, 9, 1);
        drain(5, 2, 1);

        // Out-of-range index: sticky err, no accumulator change
        send(7, 4, 0);
        send(0, 6, 1);
        check("bad_c0", model_acc[0], 6);
        drain(0, 0, 0);
        send(2, 1, 1);
        drain(0, 0, 0);

        // Reset in the middle of a drain
        send(0, 7, 0);
        send(3, 2, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("mid_out_idx", bus.out_idx, 2);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_coeff", bus.out_coeff, 0);
        check("mid_rst_out_idx", bus.out_idx, 0);
        check("mid_rst_out_last", bus.out_last, 0);
        check("mid_rst_err", bus.err, 0);
        model_clear();
        model_err = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send(1, 1, 1);
        drain(0, 0, 0);

        // Randomized products
        for (int t = 0; t < 25; t++) begin
            int nterms;
            nterms = int'($urandom_range(1, 8));
            for (int j = 0; j < nterms; j++) begin
                int idx;
                idx = ($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, 2 * N - 2));
                send(idx, int'($urandom_range(0, MASK)), (j == nterms - 1));
            end
            drain(int'($urandom_range(0, 3)), 2, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
